// File: rtl/dc6xx_spad.sv
// Scratchpad register-file stage: TMP/GPR/IPR banks behind the SPA decoder,
// with R/M operand latches and a post-reset clear sequence.
module dc6xx_spad #(
    parameter int WIDTH       = 32,
    parameter int INIT_CYCLES = 16
) (
    input  logic             m_clk_l,
    input  logic             reset_h,
    input  logic             d_clk_en_h,
    input  logic             phase_h,
    input  logic [3:0]       rspa_h,
    input  logic [3:0]       mspa_h,
    input  logic             rcs_tmp_l,
    input  logic             rcs_gpr_l,
    input  logic             rcs_ipr_l,
    input  logic             mcs_tmp_l,
    input  logic [WIDTH-1:0] wbus_h,
    output logic [WIDTH-1:0] rbus_h,
    output logic [WIDTH-1:0] mbus_h,
    output logic             init_busy_h
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   rbus_q, rbus_d;
    logic [WIDTH-1:0]   mbus_q, mbus_d;

    logic [WIDTH-1:0]   tmpShared [8];
    logic [WIDTH-1:0]   tmpRPriv  [8];
    logic [WIDTH-1:0]   tmpMPriv  [8];
    logic [WIDTH-1:0]   gpr       [16];
    logic [WIDTH-1:0]   ipr       [16];

    logic [WIDTH-1:0]   rTmpData, mTmpData, rRead, mRead;
    logic               doClear, doWrite;

    // Address bit 3 selects the port-private TMP half; 0-7 is shared by both ports.
    always_comb begin
        rTmpData = rspa_h[3] ? tmpRPriv[rspa_h[2:0]] : tmpShared[rspa_h[2:0]];
        mTmpData = mspa_h[3] ? tmpMPriv[mspa_h[2:0]] : tmpShared[mspa_h[2:0]];

        if (!rcs_gpr_l)
            rRead = gpr[rspa_h];
        else if (!rcs_ipr_l)
            rRead = ipr[rspa_h];
        else if (!rcs_tmp_l)
            rRead = rTmpData;
        else
            rRead = '1;

        mRead = !mcs_tmp_l ? mTmpData : '1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rbus_d  = rbus_q;
        mbus_d  = mbus_q;
        case (state_q)
            INIT: begin
                cnt_d  = cnt_q + 4'd1;
                rbus_d = '0;
                mbus_d = '0;
                if (cnt_q == 4'(INIT_CYCLES - 1))
                    state_d = RUN;
            end
            RUN: begin
                if (d_clk_en_h && !phase_h) begin
                    rbus_d = rRead;
                    mbus_d = mRead;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge m_clk_l) begin
        if (reset_h) begin
            state_q <= INIT;
            cnt_q   <= '0;
            rbus_q  <= '0;
            mbus_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rbus_q  <= rbus_d;
            mbus_q  <= mbus_d;
        end
    end

    assign doClear = !reset_h && (state_q == INIT);
    assign doWrite = !reset_h && (state_q == RUN) && d_clk_en_h && phase_h;

    // Both TMP ports may target the same shared word; the data is identical then.
    always_ff @(posedge m_clk_l) begin
        if (doClear) begin
            gpr[cnt_q] <= '0;
            ipr[cnt_q] <= '0;
            if (cnt_q[3]) begin
                tmpRPriv[cnt_q[2:0]] <= '0;
                tmpMPriv[cnt_q[2:0]] <= '0;
            end else begin
                tmpShared[cnt_q[2:0]] <= '0;
            end
        end else if (doWrite) begin
            if (!rcs_gpr_l)
                gpr[rspa_h] <= wbus_h;
            if (!rcs_ipr_l)
                ipr[rspa_h] <= wbus_h;
            if (!rcs_tmp_l) begin
                if (rspa_h[3])
                    tmpRPriv[rspa_h[2:0]] <= wbus_h;
                else
                    tmpShared[rspa_h[2:0]] <= wbus_h;
            end
            if (!mcs_tmp_l) begin
                if (mspa_h[3])
                    tmpMPriv[mspa_h[2:0]] <= wbus_h;
                else
                    tmpShared[mspa_h[2:0]] <= wbus_h;
            end
        end
    end

    assign rbus_h      = rbus_q;
    assign mbus_h      = mbus_q;
    assign init_busy_h = (state_q == INIT);

endmodule
